// File: rtl/irq_sequencer_if.sv
// Bundles the IRQ lines, core handshake (boundary/reti), config port and PC jump outputs.
// master = core/stimulus side, slave = irq_sequencer.
interface irq_sequencer_if #(
    parameter int NIRQ = 8
);
    logic [NIRQ-1:0] irq;
    logic            boundary;
    logic            reti;
    logic            cfg_we;
    logic [1:0]      cfg_addr;
    logic [15:0]     cfg_wdata;
    logic [15:0]     cfg_rdata;
    logic            int_jmp;
    logic [15:0]     int_addr;
    logic            int_active;
    logic [3:0]      int_id;

    modport master (
        output irq, boundary, reti, cfg_we, cfg_addr, cfg_wdata,
        input  cfg_rdata, int_jmp, int_addr, int_active, int_id
    );

    modport slave (
        input  irq, boundary, reti, cfg_we, cfg_addr, cfg_wdata,
        output cfg_rdata, int_jmp, int_addr, int_active, int_id
    );
endinterface

// File: rtl/irq_sequencer.sv
// Prioritized single-level interrupt sequencer: sync/edge-detect IRQs, take lowest eligible index at a boundary.
// Latency: irq to PENDING 3 edges, take to int_jmp 1 edge; no backpressure, service held until reti.
module irq_sequencer #(
    parameter int          NIRQ      = 8,
    parameter logic [15:0] VEC_BASE  = 16'hFF00,
    parameter int          VEC_SHIFT = 2
) (
    input  logic            CLK,
    input  logic            RST,
    irq_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TAKE    = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [NIRQ-1:0] r_sync1;
    logic [NIRQ-1:0] r_sync2;
    logic [NIRQ-1:0] r_prev;
    logic [NIRQ-1:0] r_pend;
    logic [NIRQ-1:0] r_en;
    logic            r_gie;

    logic            r_jmp;
    logic [15:0]     r_addr;
    logic            r_active;
    logic [3:0]      r_id;

    logic [NIRQ-1:0] w_rise;
    logic [NIRQ-1:0] w_elig;
    logic [NIRQ-1:0] w_onehot;
    logic [NIRQ-1:0] w_w1c;
    logic [NIRQ-1:0] w_take_clr;
    logic [NIRQ-1:0] w_pend_nxt;
    logic [3:0]      w_win;
    logic [15:0]     w_vec;
    logic            w_take;
    logic [15:0]     w_rdata;
    logic            w_unused_wdata;

    assign w_rise   = r_sync2 & ~r_prev;
    assign w_elig   = r_pend & r_en;
    // Isolate the lowest set bit: that is the highest-priority eligible request.
    assign w_onehot = w_elig & (~w_elig + NIRQ'(1));

    always_comb begin
        w_win = '0;
        for (int i = 0; i < NIRQ; i++) begin
            if (w_onehot[i]) begin
                w_win = 4'(i);
            end
        end
    end

    assign w_vec      = VEC_BASE + ({12'b0, w_win} << VEC_SHIFT);
    assign w_w1c      = (bus.cfg_we && bus.cfg_addr == 2'd1) ? bus.cfg_wdata[NIRQ-1:0] : '0;
    assign w_take_clr = w_take ? w_onehot : '0;
    // A new edge in the same cycle as any clear keeps the bit pending.
    assign w_pend_nxt = (r_pend & ~(w_w1c | w_take_clr)) | w_rise;

    // Write-data bits above the implemented register widths are ignored.
    assign w_unused_wdata = ^bus.cfg_wdata;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_pend  <= '0;
            r_en    <= '0;
            r_gie   <= 1'b0;
        end else begin
            r_sync1 <= bus.irq;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_pend  <= w_pend_nxt;
            if (bus.cfg_we && bus.cfg_addr == 2'd0) begin
                r_en <= bus.cfg_wdata[NIRQ-1:0];
            end
            if (bus.cfg_we && bus.cfg_addr == 2'd2) begin
                r_gie <= bus.cfg_wdata[0];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Take decision sees register values from before any same-cycle cfg write.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_gie && (|w_elig) && bus.boundary) begin
                    w_take      = 1'b1;
                    w_state_nxt = S_TAKE;
                end
            end
            S_TAKE:    w_state_nxt = S_SERVICE;
            S_SERVICE: begin
                if (bus.reti) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_jmp    <= 1'b0;
            r_addr   <= '0;
            r_active <= 1'b0;
            r_id     <= '0;
        end else begin
            r_jmp <= w_take;
            if (w_take) begin
                r_addr <= w_vec;
                r_id   <= w_win;
            end
            if (r_state == S_TAKE) begin
                r_active <= 1'b1;
            end else if (r_state == S_SERVICE && bus.reti) begin
                r_active <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.cfg_addr)
            2'd0:    w_rdata[NIRQ-1:0] = r_en;
            2'd1:    w_rdata[NIRQ-1:0] = r_pend;
            2'd2:    w_rdata[0]        = r_gie;
            default: w_rdata[4:0]      = {r_active, r_id};
        endcase
    end

    assign bus.cfg_rdata  = w_rdata;
    assign bus.int_jmp    = r_jmp;
    assign bus.int_addr   = r_addr;
    assign bus.int_active = r_active;
    assign bus.int_id     = r_id;

endmodule
